// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: rotating-priority arbitration over out_width
// requesters, registered one-hot grant plus binary index, one dead (GAP)
// cycle between consecutive grants.
// Optional build macro RR_SCHED_TIMEOUT_EN: force-release a grant after
// MAX_HOLD consecutive GRANT cycles while the owner still requests.
module rr_grant_sched #(
  parameter int in_width  = 3,
  parameter int out_width = 8,
  parameter int MAX_HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [out_width-1:0] req,
  output logic [out_width-1:0] gnt,
  output logic [in_width-1:0]  gnt_idx,
  output logic                 gnt_valid,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Elaboration-time parameter sanity checks
  if (out_width < 2 || out_width > (1 << in_width)) begin : g_bad_width
    $error("rr_grant_sched: out_width must be in 2..2^in_width");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_grant_sched: MAX_HOLD must be in 1..255");
  end

  state_t                 state, nxt_state;
  logic [in_width-1:0]    last, nxt_last;
  logic [7:0]             hold_cnt, nxt_hold;
  logic [out_width-1:0]   nxt_gnt;
  logic [in_width-1:0]    nxt_idx;
  logic                   nxt_valid, nxt_busy;

  logic                   arb_found;
  logic [in_width-1:0]    arb_idx;
  logic [in_width-1:0]    cand;
  int unsigned            cand_w;

  // Rotating-priority search starting one past the last owner, with wrap
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_w    = 0;
    cand      = '0;
    for (int unsigned i = 0; i < out_width; i++) begin
      cand_w = (32'(last) + 1 + i) % out_width;
      cand   = in_width'(cand_w);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Next-state and next-output decode; en low overrides every transition
  always_comb begin
    nxt_state = state;
    nxt_gnt   = gnt;
    nxt_idx   = gnt_idx;
    nxt_valid = gnt_valid;
    nxt_busy  = busy;
    nxt_last  = last;
    nxt_hold  = hold_cnt;

    unique case (state)
      IDLE, GAP: begin
        if (arb_found) begin
          nxt_state = GRANT;
          nxt_gnt   = out_width'(1) << arb_idx;
          nxt_idx   = arb_idx;
          nxt_valid = 1'b1;
          nxt_busy  = 1'b1;
          nxt_last  = arb_idx;
          nxt_hold  = 8'd1;
        end else begin
          nxt_state = IDLE;
          nxt_gnt   = '0;
          nxt_idx   = '0;
          nxt_valid = 1'b0;
          nxt_busy  = 1'b0;
          nxt_hold  = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          nxt_state = GAP;
          nxt_gnt   = '0;
          nxt_idx   = '0;
          nxt_valid = 1'b0;
          nxt_busy  = 1'b1;
          nxt_hold  = '0;
        end
`ifdef RR_SCHED_TIMEOUT_EN
        else if (hold_cnt == 8'(MAX_HOLD)) begin
          // last already names the evicted owner, so others win next
          nxt_state = GAP;
          nxt_gnt   = '0;
          nxt_idx   = '0;
          nxt_valid = 1'b0;
          nxt_busy  = 1'b1;
          nxt_hold  = '0;
        end
`endif
        else if (hold_cnt != 8'hFF) begin
          nxt_hold = hold_cnt + 8'd1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_gnt   = '0;
        nxt_idx   = '0;
        nxt_valid = 1'b0;
        nxt_busy  = 1'b0;
        nxt_hold  = '0;
      end
    endcase

    if (!en) begin
      nxt_state = IDLE;
      nxt_gnt   = '0;
      nxt_idx   = '0;
      nxt_valid = 1'b0;
      nxt_busy  = 1'b0;
      nxt_hold  = '0;
      nxt_last  = last;
    end
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
      hold_cnt  <= '0;
      last      <= in_width'(out_width - 1);
    end else begin
      state     <= nxt_state;
      gnt       <= nxt_gnt;
      gnt_idx   <= nxt_idx;
      gnt_valid <= nxt_valid;
      busy      <= nxt_busy;
      hold_cnt  <= nxt_hold;
      last      <= nxt_last;
    end
  end

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed self-checking bench for rr_grant_sched (8 requesters, 3-bit index).
// Expected values are hand-derived; the timeout scenario follows the build
// macro RR_SCHED_TIMEOUT_EN.
module tb_rr_grant_sched;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;

  int total = 0;
  int bad   = 0;

  rr_grant_sched #(
    .in_width (3),
    .out_width(8),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected packed view {busy, gnt_valid, gnt_idx, gnt}
  function automatic logic [12:0] pack(input bit on, input int idx, input bit b);
    logic [7:0] g;
    logic [2:0] ix;
    g  = on ? 8'(1 << idx) : 8'h00;
    ix = on ? 3'(idx) : 3'd0;
    return {b, on, ix, g};
  endfunction

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] r);
    rst_n = 1'b0;
    en    = 1'b1;
    req   = r;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] obs, exp;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    #2;
    obs = {busy, gnt_valid, gnt_idx, gnt};
    exp = pack(0, 0, 0);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs, exp);
    end
    step();
    rst_n = 1'b1;
    step();
    obs = {busy, gnt_valid, gnt_idx, gnt};
    exp = pack(1, 0, 1);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL first_grant: got %h want %h", obs, exp);
    end
  endtask

  // Owner holds 2 cycles, drops for one, reasserts; expect 1,2,...,7,0
  task automatic test_rotation();
    logic [12:0] obs, exp;
    int owner;
    int nxt;
    owner = 0;
    for (int k = 0; k < 8; k++) begin
      nxt = (owner + 1) % 8;
      step();
      obs = {busy, gnt_valid, gnt_idx, gnt};
      exp = pack(1, owner, 1);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rot_hold[%0d]: got %h want %h", k, obs, exp);
      end
      req = 8'hFF & ~8'(1 << owner);
      step();
      obs = {busy, gnt_valid, gnt_idx, gnt};
      exp = pack(0, 0, 1);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rot_gap[%0d]: got %h want %h", k, obs, exp);
      end
      req = 8'hFF;
      step();
      obs = {busy, gnt_valid, gnt_idx, gnt};
      exp = pack(1, nxt, 1);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rot_next[%0d]: got %h want %h", k, obs, exp);
      end
      owner = nxt;
    end
  endtask

  // req=8'h24 with single-cycle ownership: grants alternate 2,5,2,5,2
  task automatic test_alternate();
    logic [12:0] obs, exp;
    int seq [5] = '{2, 5, 2, 5, 2};
    req = 8'h24;
    step();
    obs = {busy, gnt_valid, gnt_idx, gnt};
    exp = pack(0, 0, 1);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL alt_first_gap: got %h want %h", obs, exp);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      obs = {busy, gnt_valid, gnt_idx, gnt};
      exp = pack(1, seq[k], 1);
      total++;
      if (obs !== exp || gnt !== 8'(1 << gnt_idx)) begin
        bad++;
        $display("FAIL alt_grant[%0d]: got %h want %h", k, obs, exp);
      end
      req = 8'h24 & ~8'(1 << seq[k]);
      step();
      req = 8'h24;
      obs = {busy, gnt_valid, gnt_idx, gnt};
      exp = pack(0, 0, 1);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL alt_gap[%0d]: got %h want %h", k, obs, exp);
      end
    end
  endtask

  // req=8'h03 held constantly from reset
  task automatic test_timeout();
    logic [12:0] obs, exp;
    int want [11];
`ifdef RR_SCHED_TIMEOUT_EN
    want = '{0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 0};
`else
    want = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    do_reset(8'h03);
    for (int c = 0; c < 11; c++) begin
      step();
      obs = {busy, gnt_valid, gnt_idx, gnt};
      exp = (want[c] < 0) ? pack(0, 0, 1) : pack(1, want[c], 1);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL timeout_cyc[%0d]: got %h want %h", c, obs, exp);
      end
    end
  endtask

  // en dropped while index 3 owns; pointer survives, next grant is 4
  task automatic test_en_drop();
    logic [12:0] obs, exp;
    do_reset(8'h08);
    step();
    step();
    obs = {busy, gnt_valid, gnt_idx, gnt};
    exp = pack(1, 3, 1);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL en_pre_grant: got %h want %h", obs, exp);
    end
    en  = 1'b0;
    req = 8'hFF;
    step();
    obs = {busy, gnt_valid, gnt_idx, gnt};
    exp = pack(0, 0, 0);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL en_low_idle: got %h want %h", obs, exp);
    end
    step();
    obs = {busy, gnt_valid, gnt_idx, gnt};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL en_low_stay: got %h want %h", obs, exp);
    end
    en = 1'b1;
    step();
    obs = {busy, gnt_valid, gnt_idx, gnt};
    exp = pack(1, 4, 1);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL en_reraise: got %h want %h", obs, exp);
    end
  endtask

  // rst_n asserted between edges while index 4 owns
  task automatic test_async_reset();
    logic [12:0] obs, exp;
    #2;
    rst_n = 1'b0;
    #1;
    obs = {busy, gnt_valid, gnt_idx, gnt};
    exp = pack(0, 0, 0);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL async_rst_now: got %h want %h", obs, exp);
    end
    req = 8'h60;
    step();
    obs = {busy, gnt_valid, gnt_idx, gnt};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL async_rst_held: got %h want %h", obs, exp);
    end
    rst_n = 1'b1;
    step();
    obs = {busy, gnt_valid, gnt_idx, gnt};
    exp = pack(1, 5, 1);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL async_rst_first: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    test_reset();
    test_rotation();
    test_alternate();
    test_timeout();
    test_en_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_sched.md
# rr_grant_sched

Round-robin grant scheduler that shares one resource among `out_width` requesters and drives a one-hot grant bus plus its binary index. It sits in front of the team's parameterized one-hot decoder and produces the `en`/`a` pair that decoder consumes. It also registers the decoded one-hot grant itself, so downstream logic sees a clean, glitch-free `gnt`. Fairness comes from a rotating priority pointer; an optional hold timeout bounds the time any one requester can keep the resource.

## Interface
- `in_width`, 3 — width of the grant index; must satisfy 2^in_width >= out_width.
- `out_width`, 8 — number of requesters (2..2^in_width).
- `MAX_HOLD`, 4 — maximum consecutive GRANT cycles per grant when the timeout is compiled in (1..255).

- `clk`  input  1  — single clock; all state changes on its rising edge.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `en`  input  1  — scheduler enable; low forces an abort to IDLE.
- `req`  input  out_width  — request vector; requester i holds `req[i]` high while it wants or uses the resource.
- `gnt`  output  out_width  — registered one-hot grant; all zero when nothing is granted.
- `gnt_idx`  output  in_width  — binary index of the granted requester; 0 when nothing is granted.
- `gnt_valid`  output  1  — high exactly when `gnt` is non-zero; this is the decoder-enable feed.
- `busy`  output  1  — high in GRANT and GAP states.

## Operation
- States: IDLE, GRANT, GAP. All outputs are registered.
- Pointer `last`: resets to out_width-1, so the first search starts at requester 0.
- Arbitration runs in IDLE and GAP:
  - Search `req` starting at index (last+1) mod out_width, upward with wrap.
  - The first set bit wins: that index becomes `gnt_idx`, `gnt` = 1<<idx, `gnt_valid`=1, `last`=idx, state→GRANT.
  - If no request is pending, go to (or stay in) IDLE with outputs zero.
- GRANT, entry and hold:
  - On entry, `hold_cnt` = 1.
  - While `req[gnt_idx]` stays high, stay in GRANT and increment `hold_cnt`, saturating at 255.
- GRANT, release:
  - If `req[gnt_idx]` is sampled low, clear `gnt`/`gnt_valid`/`gnt_idx` and go to GAP.
  - Timeout release is described under Configuration.
- GAP: one mandatory dead cycle with no grant, then arbitrate as above.
- `en` low at any edge: state→IDLE, all grant outputs cleared, `hold_cnt` cleared, `last` preserved. This has priority over every other transition.
- Requests for indices >= out_width do not exist; `gnt_idx` never exceeds out_width-1.
- Changes to `req` bits other than the granted one have no effect during GRANT.

## Timing
- Reset (async assert): state=IDLE, `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `busy`=0, `hold_cnt`=0, `last`=out_width-1.
- Reset deassertion is taken synchronously; the first arbitration happens at the first edge after release.
- Request-to-grant latency is 1 cycle from IDLE: `req` seen at edge N gives `gnt` valid after edge N.
- Release-to-next-grant:
  - Owner's `req` low at edge N: `gnt`=0 after edge N (GAP).
  - Next grant appears after edge N+1.
  - Minimum dead time is exactly 1 cycle.
- A requester re-asserting during GAP is arbitrated at the GAP edge with normal pointer priority.
- `en` and `req` rising together in IDLE: grant after that same edge.
- `en` falling during GRANT: `gnt`=0 after that edge, with no GAP cycle.

## Configuration
- `RR_SCHED_TIMEOUT_EN` defined:
  - In GRANT, if `hold_cnt`==MAX_HOLD and `req[gnt_idx]` is still high, the grant is force-released at that edge and the state goes to GAP.
  - Because `last` already points at the evicted requester, any other pending requester wins next.
  - A sole requester regains the grant after the GAP cycle.
- Not defined: no timeout; the grant is held until `req[gnt_idx]` drops or `en` falls. `hold_cnt` logic may be removed.

## Test plan
- Reset with `req`=8'hFF, `en`=1 → after the first edge past reset, `gnt`=8'h01, `gnt_idx`=0, `gnt_valid`=1.
- `req`=8'hFF; each owner drops its `req` bit for 1 cycle after 2 grant cycles, then reasserts → grant order 0,1,2,…,7,0, with exactly one zero-grant cycle between grants.
- `req`=8'h24, owner releases → grants alternate 2,5,2,5; `gnt_idx` and `gnt` stay consistent (`gnt` == 1<<`gnt_idx`) every cycle.
- With `RR_SCHED_TIMEOUT_EN`, MAX_HOLD=4, `req`=8'h03 held constantly → requester 0 holds 4 cycles, 1 GAP cycle, requester 1 holds 4 cycles, repeating. Without the macro, requester 0 holds indefinitely.
- `en` dropped mid-GRANT on index 3 → `gnt`=0 and `busy`=0 the next cycle. On `en` re-raise with `req`=8'hFF, the grant goes to index 4.
- `rst_n` asserted mid-GRANT (asynchronous, between edges) → all outputs are 0 immediately, and the first post-reset grant is the lowest pending index.
